// File: rtl/ibex_mult_pext_seq.sv
// rtl/ibex_mult_pext_seq.sv - Pext 32x32 / 32x16 multi-cycle multiply sequencer with accumulate
// One shared multiplier is stepped over the operand halves; the low partial is held in imd_q.
module ibex_mult_pext_seq (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mult_en_i,
   input  logic [1:0]  mult_mode_i,
   input  logic [1:0]  cycle_count_i,
   input  logic        crossed_i,
   input  logic        accum_i,
   input  logic        accum_sub_i,
   input  logic        accum_hi_i,
   input  logic        accum_sat_i,
   input  logic        signed_a_i,
   input  logic        signed_b_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [31:0] rd_i,
   output logic [63:0] prod_o,
   output logic [31:0] result_o,
   output logic        ov_o,
   output logic        mult_valid_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP_HI = 2'd1,
      ACCUM   = 2'd2
   } state_e;

   localparam logic [1:0] MODE_32X16 = 2'd2;
   localparam logic [1:0] MODE_32X32 = 2'd3;

   state_e      state_q, state_d;
   logic [47:0] imd_q, imd_d;
   logic [63:0] acc_q, acc_d;

   logic        is_32x16, is_32x32, cc_three;
   logic [15:0] b_half;
   logic        b_sext, pp_sext, imd_sext;
   logic [47:0] a_ext, b_ext, pp;
   logic [63:0] pp64, imd64, prod_hi;
   logic [31:0] acc_word, acc_res;
   logic [32:0] rd33, word33, sum33;
   logic        acc_ov;

   logic        valid;
   logic [63:0] prod;
   logic [31:0] result;
   logic        ov;

   assign is_32x16 = (mult_mode_i == MODE_32X16);
   assign is_32x32 = (mult_mode_i == MODE_32X32);
   assign cc_three = (cycle_count_i == 2'b11);

   always_comb begin
      b_half = op_b_i[15:0];
      b_sext = 1'b0;
      if (state_q == STEP_HI) begin
         b_half = op_b_i[31:16];
         b_sext = signed_b_i;
      end else if (is_32x16) begin
         b_half = crossed_i ? op_b_i[31:16] : op_b_i[15:0];
         b_sext = signed_b_i;
      end
   end

   // 33x17 signed product; only its low 48 bits are kept, which is exact for every operand mix
   assign a_ext = {{16{signed_a_i & op_a_i[31]}}, op_a_i};
   assign b_ext = {{32{b_sext & b_half[15]}}, b_half};
   assign pp    = a_ext * b_ext;

   // A partial can only be negative when one of its factors is signed
   assign pp_sext  = (signed_a_i | b_sext) & pp[47];
   assign imd_sext = signed_a_i & imd_q[47];
   assign pp64     = {{16{pp_sext}}, pp};
   assign imd64    = {{16{imd_sext}}, imd_q};
   assign prod_hi  = (pp64 << 16) + imd64;

   always_comb begin
      acc_word = accum_hi_i ? acc_q[63:32] : acc_q[31:0];
      word33   = {acc_word[31], acc_word};
      rd33     = {rd_i[31], rd_i};
      if (!accum_i) begin
         sum33 = word33;
      end else if (accum_sub_i) begin
         sum33 = rd33 - word33;
      end else begin
         sum33 = rd33 + word33;
      end
      acc_ov  = 1'b0;
      acc_res = sum33[31:0];
      if (accum_sat_i && (sum33[32] != sum33[31])) begin
         acc_ov  = 1'b1;
         acc_res = sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         imd_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         imd_q   <= imd_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      imd_d   = imd_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (mult_en_i && is_32x32) begin
               imd_d   = pp;
               state_d = STEP_HI;
            end
         end
         STEP_HI: begin
            if (mult_en_i && cc_three) begin
               acc_d   = prod_hi;
               state_d = ACCUM;
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid  = 1'b0;
      prod   = '0;
      result = '0;
      ov     = 1'b0;
      case (state_q)
         IDLE: begin
            if (mult_en_i && !mult_mode_i[1]) begin
               valid = 1'b1;
            end else if (mult_en_i && is_32x16) begin
               valid  = 1'b1;
               prod   = pp64;
               result = pp64[31:0];
            end
         end
         STEP_HI: begin
            if (mult_en_i && !cc_three) begin
               valid  = 1'b1;
               prod   = prod_hi;
               result = prod_hi[31:0];
            end
         end
         ACCUM: begin
            if (mult_en_i) begin
               valid  = 1'b1;
               prod   = acc_q;
               result = acc_res;
               ov     = acc_ov;
            end
         end
         default: valid = 1'b0;
      endcase
   end

   // Reset forces every output low even while the combinational IDLE paths see mult_en_i
   assign mult_valid_o = rst_ni & valid;
   assign prod_o       = rst_ni ? prod : '0;
   assign result_o     = rst_ni ? result : '0;
   assign ov_o         = rst_ni & ov;
   assign busy_o       = rst_ni & (state_q != IDLE);

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// tb/tb_ibex_mult_pext_seq.sv - self-checking bench for ibex_mult_pext_seq
module tb_ibex_mult_pext_seq;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        mult_en_i;
   logic [1:0]  mult_mode_i;
   logic [1:0]  cycle_count_i;
   logic        crossed_i, accum_i, accum_sub_i, accum_hi_i, accum_sat_i;
   logic        signed_a_i, signed_b_i;
   logic [31:0] op_a_i, op_b_i, rd_i;
   logic [63:0] prod_o;
   logic [31:0] result_o;
   logic        ov_o, mult_valid_o, busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] last_prod;
   logic [31:0] last_res;
   logic        last_ov;

   typedef struct {
      int          lat;
      logic [63:0] prod;
      logic [31:0] res;
      logic        ov;
   } exp_t;

   localparam longint SMAX = 64'sh7FFF_FFFF;
   localparam longint SMIN = -64'sh8000_0000;

   always #5 clk = ~clk;

   ibex_mult_pext_seq dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .mult_en_i     (mult_en_i),
      .mult_mode_i   (mult_mode_i),
      .cycle_count_i (cycle_count_i),
      .crossed_i     (crossed_i),
      .accum_i       (accum_i),
      .accum_sub_i   (accum_sub_i),
      .accum_hi_i    (accum_hi_i),
      .accum_sat_i   (accum_sat_i),
      .signed_a_i    (signed_a_i),
      .signed_b_i    (signed_b_i),
      .op_a_i        (op_a_i),
      .op_b_i        (op_b_i),
      .rd_i          (rd_i),
      .prod_o        (prod_o),
      .result_o      (result_o),
      .ov_o          (ov_o),
      .mult_valid_o  (mult_valid_o),
      .busy_o        (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full-width 64-bit arithmetic on the extended operands
   function automatic exp_t model(input logic [1:0] mode, input logic [1:0] cc, input logic crossed,
                                  input logic accum, input logic sub, input logic hi, input logic sat,
                                  input logic sa, input logic sb,
                                  input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
      exp_t        e;
      logic [63:0] av, bv;
      logic [15:0] b16;
      logic [31:0] word;
      longint      s;
      e.lat = 1; e.prod = '0; e.res = '0; e.ov = 1'b0;
      av = sa ? {{32{a[31]}}, a} : {32'b0, a};
      if (mode == 2'd2) begin
         b16    = crossed ? b[31:16] : b[15:0];
         bv     = sb ? {{48{b16[15]}}, b16} : {48'b0, b16};
         e.prod = av * bv;
         e.res  = e.prod[31:0];
      end else if (mode == 2'd3) begin
         bv     = sb ? {{32{b[31]}}, b} : {32'b0, b};
         e.prod = av * bv;
         if (cc == 2'b11) begin
            e.lat = 3;
            word  = hi ? e.prod[63:32] : e.prod[31:0];
            if (!accum)   s = longint'($signed(word));
            else if (sub) s = longint'($signed(rd)) - longint'($signed(word));
            else          s = longint'($signed(rd)) + longint'($signed(word));
            if (sat && s > SMAX) begin
               e.res = 32'h7FFF_FFFF; e.ov = 1'b1;
            end else if (sat && s < SMIN) begin
               e.res = 32'h8000_0000; e.ov = 1'b1;
            end else begin
               e.res = s[31:0];
            end
         end else begin
            e.lat = 2;
            e.res = e.prod[31:0];
         end
      end
      return e;
   endfunction

   task automatic drive(input logic [1:0] mode, input logic [1:0] cc, input logic crossed,
                        input logic accum, input logic sub, input logic hi, input logic sat,
                        input logic sa, input logic sb,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
      mult_mode_i = mode; cycle_count_i = cc; crossed_i = crossed;
      accum_i = accum; accum_sub_i = sub; accum_hi_i = hi; accum_sat_i = sat;
      signed_a_i = sa; signed_b_i = sb; op_a_i = a; op_b_i = b; rd_i = rd;
      mult_en_i = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the valid cycle with mult_en_i still high
   task automatic run_op(input logic [1:0] mode, input logic [1:0] cc, input logic crossed,
                         input logic accum, input logic sub, input logic hi, input logic sat,
                         input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
      exp_t e;
      int   cyc;
      logic got;
      e = model(mode, cc, crossed, accum, sub, hi, sat, sa, sb, a, b, rd);
      drive(mode, cc, crossed, accum, sub, hi, sat, sa, sb, a, b, rd);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 6) begin
         @(negedge clk);
         cyc++;
         chk("busy", {63'b0, busy_o}, {63'b0, cyc > 1});
         if (mult_valid_o) got = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("valid_seen", {63'b0, got}, 64'd1);
      chk("latency", 64'(cyc), 64'(e.lat));
      if (got) begin
         chk("prod", prod_o, e.prod);
         chk("result", {32'b0, result_o}, {32'b0, e.res});
         chk("ov", {63'b0, ov_o}, {63'b0, e.ov});
         last_prod = prod_o; last_res = result_o; last_ov = ov_o;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_cycle();
      mult_en_i = 1'b0;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_ni = 1'b0;
      drive(2'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h0003_0003, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {63'b0, mult_valid_o}, 64'd0);
      chk("rst_prod", prod_o, 64'd0);
      chk("rst_busy", {63'b0, busy_o}, 64'd0);
      rst_ni = 1'b1;
      mult_en_i = 1'b0;
      @(posedge clk); #1;

      run_op(2'd3, 2'b01, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0);
      chk("d_s32_neg", last_prod, 64'hFFFF_FFFF_FFFF_FFFE);
      idle_cycle();
      run_op(2'd3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      chk("d_u32_max", last_prod, 64'hFFFF_FFFE_0000_0001);
      run_op(2'd3, 2'b01, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h0);
      chk("d_s32_min", last_prod, 64'h4000_0000_0000_0000);
      idle_cycle();
      run_op(2'd3, 2'b11, 0, 1, 0, 0, 0, 1, 1, 32'd3, 32'd5, 32'd10);
      chk("d_acc_add", {32'b0, last_res}, 64'd25);
      run_op(2'd3, 2'b11, 0, 1, 1, 0, 0, 1, 1, 32'd3, 32'd5, 32'd10);
      chk("d_acc_sub", {32'b0, last_res}, 64'h0000_0000_FFFF_FFFB);
      idle_cycle();
      run_op(2'd3, 2'b11, 0, 1, 0, 1, 1, 1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      chk("d_sat_prod", last_prod, 64'h3FFF_FFFF_0000_0001);
      chk("d_sat_res", {32'b0, last_res}, 64'h0000_0000_7FFF_FFFF);
      chk("d_sat_ov", {63'b0, last_ov}, 64'd1);
      run_op(2'd3, 2'b11, 0, 1, 0, 1, 0, 1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      chk("d_wrap_res", {32'b0, last_res}, 64'h0000_0000_BFFF_FFFE);
      chk("d_wrap_ov", {63'b0, last_ov}, 64'd0);
      run_op(2'd2, 2'b00, 1, 0, 0, 0, 0, 1, 1, 32'h0001_0000, 32'hFFFF_0003, 32'h0);
      chk("d_x16_cross", last_prod, 64'hFFFF_FFFF_FFFF_0000);
      run_op(2'd2, 2'b00, 0, 0, 0, 0, 0, 1, 1, 32'h0001_0000, 32'hFFFF_0003, 32'h0);
      chk("d_x16_low", last_prod, 64'h0000_0000_0003_0000);
      run_op(2'd0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 32'h1111_1111, 32'h2222_2222, 32'h0);
      chk("d_m8_prod", last_prod, 64'd0);
      idle_cycle();

      // Abort in STEP_HI
      drive(2'd3, 2'b11, 0, 1, 0, 0, 0, 1, 1, 32'd7, 32'd9, 32'd1);
      @(negedge clk);
      chk("ab1_valid", {63'b0, mult_valid_o}, 64'd0);
      @(posedge clk); #1;
      mult_en_i = 1'b0;
      @(negedge clk);
      chk("ab1_busy", {63'b0, busy_o}, 64'd1);
      chk("ab1_valid2", {63'b0, mult_valid_o}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ab1_idle", {63'b0, busy_o}, 64'd0);
      @(posedge clk); #1;

      // Abort in ACCUM
      drive(2'd3, 2'b11, 0, 1, 0, 0, 0, 1, 1, 32'd7, 32'd9, 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      mult_en_i = 1'b0;
      @(negedge clk);
      chk("ab2_busy", {63'b0, busy_o}, 64'd1);
      chk("ab2_valid", {63'b0, mult_valid_o}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ab2_idle", {63'b0, busy_o}, 64'd0);
      @(posedge clk); #1;

      // Reset while in STEP_HI
      drive(2'd3, 2'b11, 0, 1, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rs_busy_pre", {63'b0, busy_o}, 64'd1);
      #1 rst_ni = 1'b0;
      #1;
      chk("rs_busy", {63'b0, busy_o}, 64'd0);
      chk("rs_valid", {63'b0, mult_valid_o}, 64'd0);
      chk("rs_prod", prod_o, 64'd0);
      @(posedge clk); #1;
      mult_en_i = 1'b0;
      rst_ni = 1'b1;
      @(posedge clk); #1;
      run_op(2'd3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'd6, 32'd7, 32'd0);
      chk("rs_after", last_prod, 64'd42);
      idle_cycle();

      for (int i = 0; i < 300; i++) begin
         logic [1:0] mode, cc;
         mode = 2'($urandom_range(0, 3));
         cc = (mode == 2'd3) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_op(mode, cc, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), pick(), pick(), pick());
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end
      mult_en_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
